// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the execution stage and the UART transmitter.
// The master side writes bytes; the slave side reports back-pressure and the serial line.
interface uart_tx_fifo_if;
  logic        tx_we;
  logic [31:0] tx_data;
  logic        tx_full;
  logic        tx_busy;
  logic        txd;

  modport master (output tx_we, tx_data, input tx_full, tx_busy, txd);
  modport slave  (input tx_we, tx_data, output tx_full, tx_busy, txd);
endinterface

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered 8N1 UART transmitter. Queues the low byte of each accepted write and
// serialises frames back-to-back on a registered, idle-high txd line.
module uart_tx_fifo #(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_AW     = 4
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_fifo_if.slave  tx_if
);
  localparam int DEPTH  = 1 << FIFO_AW;
  localparam int BAUD_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0]  BAUD_LOAD  = BAUD_W'(CLK_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   COUNT_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   COUNT_ONE  = (FIFO_AW + 1)'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic [1:0]         r_state;
  logic [BAUD_W-1:0]  r_baud;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic               r_txd;

  logic w_full;
  logic w_empty;
  logic w_baud_done;
  logic w_push;
  logic w_pop;
  logic w_unused_hi;

  assign w_full      = (r_count == COUNT_FULL);
  assign w_empty     = (r_count == '0);
  assign w_baud_done = (r_baud == '0);
  // Full is judged on the registered count, so a pop on the same edge never frees a slot early.
  assign w_push      = tx_if.tx_we & ~w_full;
  assign w_pop       = ~w_empty & ((r_state == S_IDLE) | ((r_state == S_STOP) & w_baud_done));
  assign w_unused_hi = |tx_if.tx_data[31:8];

  assign tx_if.tx_full = w_full;
  assign tx_if.tx_busy = (r_state != S_IDLE) | ~w_empty;
  assign tx_if.txd     = r_txd;

  // NOTE: the storage array has no reset; only pointers and count define its valid contents.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= tx_if.tx_data[7:0];
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + COUNT_ONE;
        2'b01:   r_count <= r_count - COUNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
    end else begin
      // txd trails the state by one cycle, which gives the two-edge write-to-start-bit latency.
      case (r_state)
        S_START: r_txd <= 1'b0;
        S_DATA:  r_txd <= r_shift[0];
        default: r_txd <= 1'b1;
      endcase

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_baud  <= BAUD_LOAD;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_baud_done) begin
            r_bit_idx <= '0;
            r_baud    <= BAUD_LOAD;
            r_state   <= S_DATA;
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        S_DATA: begin
          if (w_baud_done) begin
            r_baud  <= BAUD_LOAD;
            r_shift <= r_shift >> 1;
            if (r_bit_idx == 3'd7) r_state   <= S_STOP;
            else                   r_bit_idx <= r_bit_idx + 1'b1;
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        S_STOP: begin
          if (w_baud_done) begin
            if (w_pop) begin
              r_shift <= r_mem[r_rd_ptr];
              r_baud  <= BAUD_LOAD;
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
